// File: rtl/aib_tx_arbiter.sv
// Packet-aware round-robin arbiter sharing one AIB adapter TX bus among NUM_REQ requesters.
// Define AIB_TX_ARB_OUT_REG_EN to register the output through a 2-entry skid buffer.
module aib_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 72,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      i_bus_clk,
  input  logic                      i_rst,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  output logic [NUM_REQ-1:0]        o_req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]        i_req_last,
  output logic                      o_bus_tx_valid,
  input  logic                      i_bus_tx_ready,
  output logic [DATA_W-1:0]         o_bus_tx_data,
  output logic [ID_W-1:0]           o_grant_id,
  output logic                      o_busy
);

  // Handshake: a beat moves on any rising edge where valid and ready are both high;
  // valid, data and last are held stable by the source until that edge.

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [ID_W-1:0]   rr_win;
  logic [ID_W-1:0]   sel;
  logic              path_valid;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;
  logic              down_ready;
  logic              accept;

  // Round-robin search starting just after the last packet winner.
  always_comb begin
    logic found;
    int   idx;
    found  = 1'b0;
    idx    = 0;
    rr_win = ptr_q;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(ptr_q) + i) % NUM_REQ;
      if (!found && i_req_valid[idx]) begin
        found  = 1'b1;
        rr_win = ID_W'(idx);
      end
    end
  end

  always_comb begin
    sel        = (state_q == LOCKED) ? owner_q : rr_win;
    path_valid = (state_q == LOCKED) ? i_req_valid[owner_q] : (|i_req_valid);
    sel_last   = i_req_last[sel];
    sel_data   = i_req_data[int'(sel)*DATA_W +: DATA_W];
  end

  assign accept = path_valid && down_ready;

  always_comb begin
    o_req_ready = '0;
    if (accept) o_req_ready[sel] = 1'b1;
  end

  // A pending un-accepted beat also locks, so the presented data cannot change under valid.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (path_valid) begin
          if (accept && sel_last) begin
            ptr_d = sel;
          end else begin
            state_d = LOCKED;
            owner_d = sel;
          end
        end
      end
      LOCKED: begin
        if (accept && sel_last) begin
          state_d = IDLE;
          ptr_d   = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_bus_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      ptr_q   <= ID_W'(NUM_REQ - 1);
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  assign o_busy = (state_q == LOCKED);

`ifdef AIB_TX_ARB_OUT_REG_EN
  logic [DATA_W-1:0] skid_data [2];
  logic [ID_W-1:0]   skid_id [2];
  logic              rd_q, wr_q;
  logic [1:0]        cnt_q;
  logic [ID_W-1:0]   last_id_q;
  logic              push, pop;

  assign down_ready = (cnt_q != 2'd2);
  assign push       = accept;
  assign pop        = (cnt_q != 2'd0) && i_bus_tx_ready;

  always_ff @(posedge i_bus_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 2; i++) begin
        skid_data[i] <= '0;
        skid_id[i]   <= '0;
      end
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      cnt_q     <= 2'd0;
      last_id_q <= '0;
    end else begin
      if (push) begin
        skid_data[wr_q] <= sel_data;
        skid_id[wr_q]   <= sel;
        wr_q            <= ~wr_q;
      end
      if (pop) begin
        rd_q      <= ~rd_q;
        last_id_q <= skid_id[rd_q];
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign o_bus_tx_valid = (cnt_q != 2'd0);
  assign o_bus_tx_data  = skid_data[rd_q];
  assign o_grant_id     = (cnt_q != 2'd0) ? skid_id[rd_q] : last_id_q;
`else
  logic [ID_W-1:0] gid_q;

  assign down_ready = i_bus_tx_ready;

  always_ff @(posedge i_bus_clk) begin
    if (i_rst)           gid_q <= '0;
    else if (path_valid) gid_q <= sel;
  end

  assign o_bus_tx_valid = path_valid;
  assign o_bus_tx_data  = sel_data;
  assign o_grant_id     = path_valid ? sel : gid_q;
`endif

endmodule

// File: tb/tb_aib_tx_arbiter.sv
// Self-checking bench for aib_tx_arbiter: directed vectors for the combinational build,
// randomized scoreboard run when AIB_TX_ARB_OUT_REG_EN is defined.
module tb_aib_tx_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 72;
  localparam int ID_W    = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic                      bus_valid;
  logic                      bus_ready;
  logic [DATA_W-1:0]         bus_data;
  logic [ID_W-1:0]           grant_id;
  logic                      busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  aib_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .i_bus_clk      (clk),
    .i_rst          (rst),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_data     (req_data),
    .i_req_last     (req_last),
    .o_bus_tx_valid (bus_valid),
    .i_bus_tx_ready (bus_ready),
    .o_bus_tx_data  (bus_data),
    .o_grant_id     (grant_id),
    .o_busy         (busy)
  );

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_data(input int r, input logic [DATA_W-1:0] v);
    req_data[r*DATA_W +: DATA_W] = v;
  endtask

`ifdef AIB_TX_ARB_OUT_REG_EN
  int seq [NUM_REQ];
  int left [NUM_REQ];
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_v;
  logic [NUM_REQ-1:0] acc;
  int beats = 0;
  int cyc_n = 0;
  logic in_pkt = 1'b0;
  logic [ID_W-1:0] pkt_id = '0;

  initial begin
    rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; bus_ready = 1'b0;
    for (int r = 0; r < NUM_REQ; r++) begin seq[r] = 0; left[r] = 0; end
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", DATA_W'(bus_valid), '0);
    check("rst_data", bus_data, '0);
    rst = 1'b0;
    while (beats < 10000 && cyc_n < 60000) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (!req_valid[r] && ($urandom_range(1, 0) == 1)) begin
          if (left[r] == 0) left[r] = $urandom_range(4, 1);
          req_valid[r] = 1'b1;
          req_last[r]  = (left[r] == 1);
          set_data(r, {req_last[r], 7'(r), 32'(seq[r]), 32'h0});
        end
      end
      bus_ready = ($urandom_range(1, 0) == 1);
      @(negedge clk);
      acc = req_valid & req_ready;
      if (bus_valid && bus_ready) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        check("rnd_beat", bus_data, exp_v);
        if (in_pkt) check("rnd_owner", DATA_W'(grant_id), DATA_W'(pkt_id));
        in_pkt = !bus_data[DATA_W-1];
        pkt_id = grant_id;
        beats++;
      end
      for (int r = 0; r < NUM_REQ; r++)
        if (acc[r]) exp_q.push_back(req_data[r*DATA_W +: DATA_W]);
      @(posedge clk);
      #1;
      cyc_n++;
      for (int r = 0; r < NUM_REQ; r++) begin
        if (acc[r]) begin
          req_valid[r] = 1'b0;
          seq[r]++;
          left[r]--;
        end
      end
    end
    check("rnd_beats_done", DATA_W'(beats >= 10000), DATA_W'(1));
    check("rnd_backlog", DATA_W'(exp_q.size() <= 3), DATA_W'(1));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
`else
  // One cycle: compare outputs at the falling edge, then advance past the next rising edge.
  task automatic cyc(input string tag, input logic vld, input logic [DATA_W-1:0] dat,
                     input logic [NUM_REQ-1:0] rdy, input logic [ID_W-1:0] gid,
                     input logic bsy);
    @(negedge clk);
    check({tag, "_valid"}, DATA_W'(bus_valid), DATA_W'(vld));
    check({tag, "_ready"}, DATA_W'(req_ready), DATA_W'(rdy));
    check({tag, "_grant"}, DATA_W'(grant_id), DATA_W'(gid));
    check({tag, "_busy"}, DATA_W'(busy), DATA_W'(bsy));
    if (vld) check({tag, "_data"}, bus_data, dat);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; bus_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc("rst", 1'b0, '0, 4'b0000, 2'd0, 1'b0);

    // All four single-beat and always valid: strict rotation 0,1,2,3,0.
    rst = 1'b0; bus_ready = 1'b1;
    for (int r = 0; r < NUM_REQ; r++) set_data(r, DATA_W'(8'h10 + r));
    req_valid = 4'b1111; req_last = 4'b1111;
    cyc("t1_g0", 1'b1, 72'h10, 4'b0001, 2'd0, 1'b0);
    cyc("t1_g1", 1'b1, 72'h11, 4'b0010, 2'd1, 1'b0);
    cyc("t1_g2", 1'b1, 72'h12, 4'b0100, 2'd2, 1'b0);
    cyc("t1_g3", 1'b1, 72'h13, 4'b1000, 2'd3, 1'b0);
    cyc("t1_g0b", 1'b1, 72'h10, 4'b0001, 2'd0, 1'b0);

    // Three-beat packet from req 2 with req 0 and 3 contending.
    req_valid = 4'b1101; req_last = 4'b1001; set_data(2, 72'hA0);
    cyc("t2_b1", 1'b1, 72'hA0, 4'b0100, 2'd2, 1'b0);
    set_data(2, 72'hA1);
    cyc("t2_b2", 1'b1, 72'hA1, 4'b0100, 2'd2, 1'b1);
    set_data(2, 72'hA2); req_last = 4'b1101;
    cyc("t2_b3", 1'b1, 72'hA2, 4'b0100, 2'd2, 1'b1);
    req_valid = 4'b1001;
    cyc("t2_r3", 1'b1, 72'h13, 4'b1000, 2'd3, 1'b0);
    req_valid = 4'b0000;
    cyc("t2_idle", 1'b0, '0, 4'b0000, 2'd3, 1'b0);

    // Downstream stalled: req 1's beat stays frozen even after req 0 arrives.
    bus_ready = 1'b0; req_valid = 4'b0010; req_last = 4'b0010; set_data(1, 72'h51);
    cyc("t3_s0", 1'b1, 72'h51, 4'b0000, 2'd1, 1'b0);
    cyc("t3_s1", 1'b1, 72'h51, 4'b0000, 2'd1, 1'b1);
    req_valid = 4'b0011; req_last = 4'b0011; set_data(0, 72'h50);
    cyc("t3_s2", 1'b1, 72'h51, 4'b0000, 2'd1, 1'b1);
    cyc("t3_s3", 1'b1, 72'h51, 4'b0000, 2'd1, 1'b1);
    cyc("t3_s4", 1'b1, 72'h51, 4'b0000, 2'd1, 1'b1);
    bus_ready = 1'b1;
    cyc("t3_acc", 1'b1, 72'h51, 4'b0010, 2'd1, 1'b1);
    req_valid = 4'b0001;
    cyc("t3_r0", 1'b1, 72'h50, 4'b0001, 2'd0, 1'b0);

    // Owner drops valid mid-packet; req 3 must not sneak in.
    req_valid = 4'b0010; req_last = 4'b0000; set_data(1, 72'h61);
    cyc("t4_b1", 1'b1, 72'h61, 4'b0010, 2'd1, 1'b0);
    req_valid = 4'b1000; req_last = 4'b1000; set_data(3, 72'h63);
    cyc("t4_gap0", 1'b0, '0, 4'b0000, 2'd1, 1'b1);
    cyc("t4_gap1", 1'b0, '0, 4'b0000, 2'd1, 1'b1);
    req_valid = 4'b1010; req_last = 4'b1010; set_data(1, 72'h62);
    cyc("t4_b2", 1'b1, 72'h62, 4'b0010, 2'd1, 1'b1);
    req_valid = 4'b1000;
    cyc("t4_r3", 1'b1, 72'h63, 4'b1000, 2'd3, 1'b0);

    // Move ptr to 0, start a packet from req 2, then reset during its second beat.
    req_valid = 4'b0001; req_last = 4'b0001; set_data(0, 72'h70);
    cyc("t5_pre", 1'b1, 72'h70, 4'b0001, 2'd0, 1'b0);
    req_valid = 4'b0100; req_last = 4'b0000; set_data(2, 72'hB0);
    cyc("t5_b1", 1'b1, 72'hB0, 4'b0100, 2'd2, 1'b0);
    set_data(2, 72'hB1); rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = 4'b0011; req_last = 4'b0011;
    set_data(0, 72'h80); set_data(1, 72'h81);
    cyc("t5_r0", 1'b1, 72'h80, 4'b0001, 2'd0, 1'b0);
    req_valid = 4'b0010;
    cyc("t5_r1", 1'b1, 72'h81, 4'b0010, 2'd1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
`endif

endmodule
